// File: rtl/xrf_wb_arbiter_pkg.sv
// Shared constants for the XRF writeback path: requester slot indices and the
// physical-register count / tag width derivation also used by the XRF itself.
package xrf_wb_arbiter_pkg;

  // Writeback requester slot assignment
  localparam int WB_ALU0 = 0;
  localparam int WB_ALU1 = 1;
  localparam int WB_LSU  = 2;
  localparam int WB_MUL  = 3;
  localparam int WB_NREQ = 4;

  // Physical register file sizing: architectural regs plus ROB-sized rename pool
  localparam int XRF_XLEN   = 32;
  localparam int XRF_ROBLEN = 16;
  localparam int XRF_PLEN   = XRF_XLEN + XRF_ROBLEN;
  localparam int XRF_PBITS  = $clog2(XRF_PLEN);

  // Width of an index into n requesters (never zero)
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xrf_wb_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit at or after i_start,
// wrapping circularly. The request vector is doubled and shifted right by the
// start index so the circular search becomes a plain lowest-bit-first search.
module xrf_wb_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_idx,
  output logic          o_valid
);

  localparam logic [SW:0] NV = (SW + 1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [SW-1:0]  w_off;
  logic           w_found;
  logic [SW:0]    w_sum;

  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_start);

  // Lowest set bit of the rotated vector is the offset from the start index
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off   = SW'(j);
        w_found = 1'b1;
      end
    end
  end

  // Undo the rotation: absolute index = (start + offset) mod N
  always_comb begin
    w_sum = {1'b0, i_start} + {1'b0, w_off};
    if (w_sum >= NV) begin
      w_sum = w_sum - NV;
    end
  end

  assign o_idx   = w_sum[SW-1:0];
  assign o_valid = w_found;
  assign o_gnt   = w_found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/xrf_wb_arbiter.sv
// XRF writeback arbiter: grants up to WPORTS of NREQ functional-unit results per
// cycle in round-robin order, registers the winners onto the XRF write ports and
// mirrors them onto the issue-queue wakeup bus. Tag 0 is the hardwired zero
// register: such results are consumed but never written or broadcast.
// Optional feature macro: XRF_WB_PERF_EN builds the saturating conflict counter;
// without it o_conflict_cnt is tied to zero and no counter flops exist.
module xrf_wb_arbiter
  import xrf_wb_arbiter_pkg::*;
#(
  parameter int XLEN   = XRF_XLEN,
  parameter int PLEN   = XRF_PLEN,
  parameter int PBITS  = $clog2(PLEN),
  parameter int NREQ   = WB_NREQ,
  parameter int WPORTS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*PBITS-1:0]   i_req_prd,
  input  logic [NREQ*XLEN-1:0]    i_req_data,
  output logic [WPORTS-1:0]       o_wen,
  output logic [WPORTS*PBITS-1:0] o_waddr,
  output logic [WPORTS*XLEN-1:0]  o_wdata,
  output logic [WPORTS-1:0]       o_wake_valid,
  output logic [WPORTS*PBITS-1:0] o_wake_tag,
  output logic [31:0]             o_conflict_cnt
);

  localparam int PTRW = ptr_bits(NREQ);

  // Circular successor of a requester index
  function automatic logic [PTRW-1:0] f_next(input logic [PTRW-1:0] idx);
    if (idx == PTRW'(NREQ - 1)) begin
      return '0;
    end
    return idx + PTRW'(1);
  endfunction

  logic [PTRW-1:0]         r_ptr;
  logic [PTRW-1:0]         w_ptr_next;
  logic [NREQ-1:0]         w_gnt [WPORTS];
  logic [PTRW-1:0]         w_idx [WPORTS];
  logic                    w_vld [WPORTS];
  logic [NREQ-1:0]         w_ready;
  logic [WPORTS-1:0]       w_wen_next;
  logic [WPORTS*PBITS-1:0] w_waddr_next;
  logic [WPORTS*XLEN-1:0]  w_wdata_next;
  logic [WPORTS-1:0]       r_wen;
  logic [WPORTS*PBITS-1:0] r_waddr;
  logic [WPORTS*XLEN-1:0]  r_wdata;

  // One picker per write port; later ports search after the previous winner
  genvar gi;
  generate
    for (gi = 0; gi < WPORTS; gi++) begin : g_pick
      logic [NREQ-1:0] w_req;
      logic [PTRW-1:0] w_start;
      if (gi == 0) begin : g_first
        assign w_req   = i_req_valid;
        assign w_start = r_ptr;
      end else begin : g_chain
        assign w_req   = i_req_valid & ~w_gnt[gi-1];
        assign w_start = f_next(w_idx[gi-1]);
      end
      xrf_wb_arbiter_rr_pick #(
        .N  (NREQ),
        .SW (PTRW)
      ) u_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .o_gnt   (w_gnt[gi]),
        .o_idx   (w_idx[gi]),
        .o_valid (w_vld[gi])
      );
    end
  endgenerate

  // Ready and pointer advance depend only on valids and the pointer
  always_comb begin
    w_ready    = '0;
    w_ptr_next = r_ptr;
    for (int p = 0; p < WPORTS; p++) begin
      w_ready = w_ready | w_gnt[p];
      if (w_vld[p]) begin
        w_ptr_next = f_next(w_idx[p]);
      end
    end
  end

  assign o_req_ready = w_ready;

  // One-hot AND-OR mux of each winner's tag and data onto its port
  always_comb begin
    w_waddr_next = '0;
    w_wdata_next = '0;
    w_wen_next   = '0;
    for (int p = 0; p < WPORTS; p++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_gnt[p][k]) begin
          w_waddr_next[p*PBITS +: PBITS] = w_waddr_next[p*PBITS +: PBITS] | i_req_prd[k*PBITS +: PBITS];
          w_wdata_next[p*XLEN +: XLEN]   = w_wdata_next[p*XLEN +: XLEN] | i_req_data[k*XLEN +: XLEN];
        end
      end
      w_wen_next[p] = w_vld[p] && (w_waddr_next[p*PBITS +: PBITS] != '0);
    end
  end

  // Round-robin pointer and registered write/wakeup stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_wen   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_wen   <= w_wen_next;
      r_waddr <= w_waddr_next;
      r_wdata <= w_wdata_next;
    end
  end

  assign o_wen        = r_wen;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_wake_valid = r_wen;
  assign o_wake_tag   = r_waddr;

  generate
    if (WPORTS == 2) begin : g_dup_chk
      // Rename never hands the same nonzero tag to two in-flight results
      a_no_dup_tag: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_vld[0] && w_vld[1] &&
          (w_waddr_next[PBITS-1:0] == w_waddr_next[2*PBITS-1:PBITS]) &&
          (w_waddr_next[PBITS-1:0] != '0)));
    end
  endgenerate

`ifdef XRF_WB_PERF_EN
  logic [31:0] r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = |(i_req_valid & ~w_ready);

  // Count cycles in which some valid requester was left waiting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule
